uart_cfg_master: RTL
====================

# uart_cfg_master

Command-side initiator for the UART configuration register file. It accepts one configuration request at a time from the host-command path: write a field, read a field, or restore defaults. It converts each request into a single-cycle valid/address/data strobe toward the register file and waits for the ack and readback. It then returns exactly one response carrying the readback data and a status code, with a timeout covering unmapped or unresponsive targets.

## Interface
- TIMEOUT_CYCLES, 15: WAIT-state cycles without ack before a timeout response; legal range 2..255.
- clk_16bd  in  1  16x baud clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  2  00 write, 01 read, 10 defaults, 11 illegal.
- req_reg  in  2  0 parity, 1 parity_type, 2 stop_bits, 3 frame_length.
- req_wdata  in  4  write value; fields 0..2 use bit 0 only.
- cfg_valid  out  1  strobe to register file, one cycle per transaction.
- cfg_address  out  4  0000 defaults, 1001 parity, 1010 parity_type, 1011 stop_bits, 1100 frame_length.
- cfg_data  out  4  write value, or 1111 for read.
- cfg_ack  in  1  register-file acknowledge.
- cfg_rdata_valid  in  1  readback valid, coincident with ack.
- cfg_rdata  in  4  readback value.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  4  captured readback; 0 for non-reads and errors.
- rsp_status  out  2  00 OK, 01 timeout, 10 protocol error, 11 illegal request.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - req_ready=1.
  - On req_valid, latch op, reg and wdata.
  - Illegal request: req_op=11, or a frame_length write with wdata=1111 (this would alias the read marker). Go directly to RESP with status 11; no bus cycle is issued.
  - Otherwise go to ISSUE.
- ISSUE
  - cfg_valid=1 with the decoded address and data; defaults drives data 0000.
  - Always go to WAIT next cycle. cfg_valid is never held for more than one cycle, because the register file re-accepts once its internal count clears.
- WAIT
  - Timeout counter starts at 0 and increments each cycle.
  - cfg_ack=1 on a read with cfg_rdata_valid=1: capture cfg_rdata, status 00.
  - cfg_ack=1 on a read without cfg_rdata_valid: status 10.
  - cfg_ack=1 on a write or defaults: status 00. If cfg_rdata_valid is also high, status 10.
  - If the counter reaches TIMEOUT_CYCLES with no ack: status 01.
  - Any of these outcomes moves to RESP.
- RESP: rsp_valid=1 for one cycle, then IDLE.
- Stray cfg_ack or cfg_rdata_valid outside WAIT is ignored.
- cfg_address and cfg_data are 0 outside ISSUE.

## Timing
- Reset values: state IDLE, req_ready=1, cfg_valid=0, cfg_address=0, cfg_data=0, rsp_valid=0, rsp_rdata=0, rsp_status=00, counter 0, latched request cleared.
- Normal transaction, with the request accepted at edge 0:
  - cfg_valid is high in cycle 1.
  - The register file acks in cycle 2.
  - rsp_valid is high in cycle 3.
  - req_ready returns high in cycle 4.
- Illegal request: rsp_valid in cycle 1.
- Timeout: rsp_valid TIMEOUT_CYCLES+2 cycles after acceptance.
- Back-to-back requests: the next cfg_valid comes no earlier than 3 cycles after the previous ack, which respects the register file's one-cycle recovery.
- Reset mid-transaction: immediate return to IDLE, no rsp_valid. A late ack after reset is ignored.
- A request held valid across RESP is not accepted until IDLE.

## Configuration
- UART_CFG_SHADOW_EN defined:
  - Adds outputs shadow_parity, shadow_parity_type, shadow_stop_bits (1 bit each) and shadow_frame_length (4 bits).
  - Reset values: 1, 0, 0, 1000.
  - An OK write updates the addressed field in the RESP cycle.
  - An OK defaults reloads all reset values.
  - An OK read overwrites the field with the readback.
- UART_CFG_SHADOW_EN undefined: these ports and registers do not exist; all other behaviour is identical.

## Structure
- Package uart_cfg_pkg holds:
  - FSM state enum.
  - req_op encodings.
  - Register address constants 0000/1001/1010/1011/1100.
  - Read marker 1111.
  - Status codes.
  - Default field values.
- One sub-module, uart_cfg_timer: a clear/enable counter with a terminal flag at TIMEOUT_CYCLES.

## Test plan
- After reset, read frame_length against the register-file model -> cfg_address=1100, cfg_data=1111, rsp_valid 3 cycles after acceptance, rsp_rdata=1000, status 00.
- Write parity=0, then read parity -> first response status 00; second rsp_rdata=0000.
- Write frame_length=1111 -> no cfg_valid, rsp_valid in cycle 1, status 11; req_op=11 gives the same result.
- Write frame_length=0111, then defaults, then read -> rsp_rdata=1000. With UART_CFG_SHADOW_EN: shadow_frame_length goes 0111, then 1000.
- Target never acks, TIMEOUT_CYCLES=4 -> rsp_valid 6 cycles after acceptance, status 01. A later normal read still completes correctly.
- Assert rst during WAIT; stray ack in IDLE; read acked without rdata_valid -> no response after reset; stray ack ignored; protocol-error read returns status 10.

Source files
------------

// File: rtl/uart_cfg_pkg.sv
// uart_cfg_pkg: shared types and constants for the UART configuration master.
// Holds the FSM state enum, request opcodes, register-file addresses, the read
// marker, response status codes, field defaults and small decode helpers.
package uart_cfg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } cfg_state_t;

   // req_op encodings
   localparam logic [1:0] OP_WRITE    = 2'b00;
   localparam logic [1:0] OP_READ     = 2'b01;
   localparam logic [1:0] OP_DEFAULTS = 2'b10;
   localparam logic [1:0] OP_ILLEGAL  = 2'b11;

   // req_reg field selectors
   localparam logic [1:0] FLD_PARITY       = 2'd0;
   localparam logic [1:0] FLD_PARITY_TYPE  = 2'd1;
   localparam logic [1:0] FLD_STOP_BITS    = 2'd2;
   localparam logic [1:0] FLD_FRAME_LENGTH = 2'd3;

   // register-file addresses
   localparam logic [3:0] ADDR_DEFAULTS     = 4'b0000;
   localparam logic [3:0] ADDR_PARITY       = 4'b1001;
   localparam logic [3:0] ADDR_PARITY_TYPE  = 4'b1010;
   localparam logic [3:0] ADDR_STOP_BITS    = 4'b1011;
   localparam logic [3:0] ADDR_FRAME_LENGTH = 4'b1100;

   // cfg_data value that tells the register file "this is a read"
   localparam logic [3:0] READ_MARKER = 4'b1111;

   // response status codes
   localparam logic [1:0] STS_OK       = 2'b00;
   localparam logic [1:0] STS_TIMEOUT  = 2'b01;
   localparam logic [1:0] STS_PROTOCOL = 2'b10;
   localparam logic [1:0] STS_ILLEGAL  = 2'b11;

   // field defaults
   localparam logic       DEF_PARITY       = 1'b1;
   localparam logic       DEF_PARITY_TYPE  = 1'b0;
   localparam logic       DEF_STOP_BITS    = 1'b0;
   localparam logic [3:0] DEF_FRAME_LENGTH = 4'b1000;

   // A frame_length write of 1111 would be indistinguishable from a read.
   function automatic logic is_illegal(input logic [1:0] op, input logic [1:0] field,
                                       input logic [3:0] wdata);
      return (op == OP_ILLEGAL) ||
             (op == OP_WRITE && field == FLD_FRAME_LENGTH && wdata == READ_MARKER);
   endfunction

   function automatic logic [3:0] bus_address(input logic [1:0] op, input logic [1:0] field);
      logic [3:0] a;
      a = ADDR_DEFAULTS;
      if (op != OP_DEFAULTS) begin
         case (field)
            FLD_PARITY:       a = ADDR_PARITY;
            FLD_PARITY_TYPE:  a = ADDR_PARITY_TYPE;
            FLD_STOP_BITS:    a = ADDR_STOP_BITS;
            default:          a = ADDR_FRAME_LENGTH;
         endcase
      end
      return a;
   endfunction

   // Single-bit fields carry their value in bit 0 only.
   function automatic logic [3:0] bus_data(input logic [1:0] op, input logic [1:0] field,
                                           input logic [3:0] wdata);
      logic [3:0] d;
      d = 4'b0000;
      if (op == OP_READ)
         d = READ_MARKER;
      else if (op == OP_WRITE)
         d = (field == FLD_FRAME_LENGTH) ? wdata : {3'b000, wdata[0]};
      return d;
   endfunction

endpackage

// File: rtl/uart_cfg_timer.sv
// uart_cfg_timer: ack-wait timeout counter with synchronous clear and enable.
// Ports: clk_16bd, rst (async, active-high), clr, en in; expired out.
// expired is high in the enabled cycle whose edge would bring the count to TIMEOUT_CYCLES.
module uart_cfg_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic clk_16bd,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] count;

   always_ff @(posedge clk_16bd or posedge rst) begin
      if (rst)
         count <= 8'd0;
      else if (clr)
         count <= 8'd0;
      else if (en)
         count <= count + 8'd1;
   end

   // The count holds the number of completed WAIT cycles; this flag fires in
   // the cycle that completes the TIMEOUT_CYCLES-th one.
   assign expired = en && (count == LAST);

endmodule

// File: rtl/uart_cfg_master.sv
// uart_cfg_master: turns one host config request into a single register-file
// strobe, waits for ack/readback with timeout, and returns one response pulse.
// Ports: req_* request handshake, cfg_* register-file strobe/ack/readback,
// rsp_* response. Optional shadow_* field copies when UART_CFG_SHADOW_EN is defined.
module uart_cfg_master
   import uart_cfg_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic       clk_16bd,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_op,
   input  logic [1:0] req_reg,
   input  logic [3:0] req_wdata,
   output logic       cfg_valid,
   output logic [3:0] cfg_address,
   output logic [3:0] cfg_data,
   input  logic       cfg_ack,
   input  logic       cfg_rdata_valid,
   input  logic [3:0] cfg_rdata,
   output logic       rsp_valid,
   output logic [3:0] rsp_rdata,
`ifdef UART_CFG_SHADOW_EN
   output logic [1:0] rsp_status,
   output logic       shadow_parity,
   output logic       shadow_parity_type,
   output logic       shadow_stop_bits,
   output logic [3:0] shadow_frame_length
`else
   output logic [1:0] rsp_status
`endif
);

   cfg_state_t state, state_nxt;

   logic [1:0] op_q;
   logic [1:0] reg_q;
   logic [3:0] wdata_q;
   logic [3:0] rdata_q;
   logic [1:0] status_q;

   logic       load_req;
   logic       set_rsp;
   logic [1:0] status_nxt;
   logic [3:0] rdata_nxt;
   logic       timer_clr;
   logic       timer_en;
   logic       timer_expired;

   uart_cfg_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk_16bd (clk_16bd),
      .rst      (rst),
      .clr      (timer_clr),
      .en       (timer_en),
      .expired  (timer_expired)
   );

   always_ff @(posedge clk_16bd or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      load_req   = 1'b0;
      set_rsp    = 1'b0;
      status_nxt = STS_OK;
      rdata_nxt  = 4'b0000;
      timer_clr  = 1'b1;
      timer_en   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (req_valid) begin
               load_req = 1'b1;
               if (is_illegal(req_op, req_reg, req_wdata)) begin
                  set_rsp    = 1'b1;
                  status_nxt = STS_ILLEGAL;
                  state_nxt  = ST_RESP;
               end else begin
                  state_nxt = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            timer_clr = 1'b0;
            timer_en  = 1'b1;
            if (cfg_ack) begin
               set_rsp   = 1'b1;
               state_nxt = ST_RESP;
               if (op_q == OP_READ) begin
                  if (cfg_rdata_valid)
                     rdata_nxt = cfg_rdata;
                  else
                     status_nxt = STS_PROTOCOL;
               end else if (cfg_rdata_valid) begin
                  // readback on a write/defaults means the target misdecoded us
                  status_nxt = STS_PROTOCOL;
               end
            end else if (timer_expired) begin
               set_rsp    = 1'b1;
               status_nxt = STS_TIMEOUT;
               state_nxt  = ST_RESP;
            end
         end
         ST_RESP: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_16bd or posedge rst) begin
      if (rst) begin
         op_q     <= OP_WRITE;
         reg_q    <= FLD_PARITY;
         wdata_q  <= 4'b0000;
         rdata_q  <= 4'b0000;
         status_q <= STS_OK;
      end else begin
         if (load_req) begin
            op_q    <= req_op;
            reg_q   <= req_reg;
            wdata_q <= req_wdata;
         end
         if (set_rsp) begin
            rdata_q  <= rdata_nxt;
            status_q <= status_nxt;
         end
      end
   end

   assign req_ready   = (state == ST_IDLE);
   assign cfg_valid   = (state == ST_ISSUE);
   assign cfg_address = (state == ST_ISSUE) ? bus_address(op_q, reg_q) : 4'b0000;
   assign cfg_data    = (state == ST_ISSUE) ? bus_data(op_q, reg_q, wdata_q) : 4'b0000;
   assign rsp_valid   = (state == ST_RESP);
   assign rsp_rdata   = rdata_q;
   assign rsp_status  = status_q;

`ifdef UART_CFG_SHADOW_EN
   // Shadows change on the edge into RESP, so they already reflect the
   // outcome while rsp_valid is high. Only OK bus outcomes reach here.
   logic shadow_upd;
   assign shadow_upd = set_rsp && (state == ST_WAIT) && (status_nxt == STS_OK);

   always_ff @(posedge clk_16bd or posedge rst) begin
      if (rst) begin
         shadow_parity       <= DEF_PARITY;
         shadow_parity_type  <= DEF_PARITY_TYPE;
         shadow_stop_bits    <= DEF_STOP_BITS;
         shadow_frame_length <= DEF_FRAME_LENGTH;
      end else if (shadow_upd) begin
         if (op_q == OP_DEFAULTS) begin
            shadow_parity       <= DEF_PARITY;
            shadow_parity_type  <= DEF_PARITY_TYPE;
            shadow_stop_bits    <= DEF_STOP_BITS;
            shadow_frame_length <= DEF_FRAME_LENGTH;
         end else begin
            case (reg_q)
               FLD_PARITY:      shadow_parity      <= (op_q == OP_READ) ? cfg_rdata[0] : wdata_q[0];
               FLD_PARITY_TYPE: shadow_parity_type <= (op_q == OP_READ) ? cfg_rdata[0] : wdata_q[0];
               FLD_STOP_BITS:   shadow_stop_bits   <= (op_q == OP_READ) ? cfg_rdata[0] : wdata_q[0];
               default:         shadow_frame_length <= (op_q == OP_READ) ? cfg_rdata : wdata_q;
            endcase
         end
      end
   end
`endif

endmodule
